reg_read_arbiter: RTL

//   Round-robin arbiter and sequencer for the single 16:1 x 16-bit read mux of the
//   8088 register bank. Up to NREQ requesters (e.g. decode, ALU operand, address

---
 rtl/reg_read_arbiter_if.sv | 31 +++
 rtl/reg_read_arbiter.sv | 111 +++++++++++
 2 files changed

// File: rtl/reg_read_arbiter_if.sv
// Bundles the register-bank read port: requests and hold in, grant, mux select and read data out.
// No storage: all signals are plain wires between the requester side and the arbiter.
// No flow control of its own; requesters hold req/addr until they see gnt.
interface reg_read_arbiter_if #(
   parameter int NREQ   = 4,
   parameter int DATA_W = 16,
   parameter int ADDR_W = 4,
   parameter int ID_W   = 2
);
   logic [NREQ-1:0]        req;
   logic [NREQ*ADDR_W-1:0] addr;
   logic                   hold;
   logic [NREQ-1:0]        gnt;
   logic [ADDR_W-1:0]      mux_sel;
   logic [DATA_W-1:0]      mux_data;
   logic [DATA_W-1:0]      rdata;
   logic                   rvalid;
   logic [ID_W-1:0]        rid;

   // Requester / register-bank side
   modport master (
      output req, addr, hold, mux_data,
      input  gnt, mux_sel, rdata, rvalid, rid
   );

   // Arbiter side
   modport slave (
      input  req, addr, hold, mux_data,
      output gnt, mux_sel, rdata, rvalid, rid
   );
endinterface

// File: rtl/reg_read_arbiter.sv
// Round-robin arbiter sequencing one shared register-bank read mux among NREQ requesters.
// Latency: req sampled at edge E -> gnt/mux_sel after E -> rdata/rvalid after E+1; one access per 2 clks.
// Backpressure: hold=1 blocks new grants only; an access already selected always completes.
module reg_read_arbiter #(
   parameter int NREQ   = 4,
   parameter int DATA_W = 16,
   parameter int ADDR_W = 4,
   parameter int ID_W   = 2
) (
   input logic               clk,
   input logic               rst,
   reg_read_arbiter_if.slave bus
);

   typedef enum logic [1:0] {IDLE, SEL, CAP} state_t;

   state_t            state_q, state_d;
   logic [ID_W-1:0]   ptr_q, ptr_d;
   logic [ID_W-1:0]   wid_q, wid_d;
   logic [NREQ-1:0]   gnt_q, gnt_d;
   logic [ADDR_W-1:0] mux_sel_q, mux_sel_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic              rvalid_q, rvalid_d;
   logic [ID_W-1:0]   rid_q, rid_d;

   logic              win_vld;
   logic [ID_W-1:0]   win_id;
   logic [ID_W:0]     scan_idx;
   logic [ID_W-1:0]   ptr_next;

   // Round-robin scan starting at ptr: first requester found wins
   always_comb begin
      win_vld  = 1'b0;
      win_id   = '0;
      scan_idx = '0;
      for (int k = 0; k < NREQ; k++) begin
         scan_idx = {1'b0, ptr_q} + (ID_W+1)'(k);
         if (scan_idx >= (ID_W+1)'(NREQ)) begin
            scan_idx = scan_idx - (ID_W+1)'(NREQ);
         end
         if (!win_vld && bus.req[scan_idx[ID_W-1:0]]) begin
            win_vld = 1'b1;
            win_id  = scan_idx[ID_W-1:0];
         end
      end
      ptr_next = (win_id == ID_W'(NREQ-1)) ? '0 : win_id + ID_W'(1);
   end

   // Next-state and output decode; mux_sel/rdata/rid hold unless updated
   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      wid_d     = wid_q;
      gnt_d     = '0;
      mux_sel_d = mux_sel_q;
      rdata_d   = rdata_q;
      rvalid_d  = 1'b0;
      rid_d     = rid_q;
      case (state_q)
         IDLE, CAP: begin
            if (!bus.hold && win_vld) begin
               state_d   = SEL;
               gnt_d     = NREQ'(1) << win_id;
               mux_sel_d = bus.addr[int'(win_id)*ADDR_W +: ADDR_W];
               wid_d     = win_id;
               ptr_d     = ptr_next;
            end else begin
               state_d = IDLE;
            end
         end
         SEL: begin
            // mux_data has had a full cycle to settle on the registered select
            state_d  = CAP;
            rdata_d  = bus.mux_data;
            rvalid_d = 1'b1;
            rid_d    = wid_q;
         end
         default: state_d = IDLE;
      endcase
   end

   // State and output registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         ptr_q     <= '0;
         wid_q     <= '0;
         gnt_q     <= '0;
         mux_sel_q <= '0;
         rdata_q   <= '0;
         rvalid_q  <= 1'b0;
         rid_q     <= '0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         wid_q     <= wid_d;
         gnt_q     <= gnt_d;
         mux_sel_q <= mux_sel_d;
         rdata_q   <= rdata_d;
         rvalid_q  <= rvalid_d;
         rid_q     <= rid_d;
      end
   end

   assign bus.gnt     = gnt_q;
   assign bus.mux_sel = mux_sel_q;
   assign bus.rdata   = rdata_q;
   assign bus.rvalid  = rvalid_q;
   assign bus.rid     = rid_q;

endmodule
